// File: rtl/pebble_loader_pkg.sv
// Shared types and constants for the Pebble program loader.
package pebble_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_BOOT  = 3'd2,
    ST_START = 3'd3,
    ST_RUN   = 3'd4,
    ST_DONE  = 3'd5
  } loader_state_t;

  localparam int          LOADER_BOOT_CYCLES = 2;
  localparam logic [15:0] LOADER_TIMEOUT     = 16'd50000;

  localparam int LOADER_IW = 9;
  localparam int LOADER_AW = 10;
  localparam int LOADER_CW = 16;

endpackage

// File: rtl/pebble_loader_sat_ctr.sv
// Width-parameterised saturating up-counter with synchronous clear and enable.
module pebble_sat_ctr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Clear has priority over counting; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/pebble_loader.sv
// Pebble program loader and run controller.
// Optional watchdog: define PEBBLE_LOADER_TIMEOUT_EN to abort a run that
// reaches LOADER_TIMEOUT cycles without cpu_done (sets err_timeout).
module pebble_loader
  import pebble_pkg::*;
#(
  parameter int IW = LOADER_IW,
  parameter int AW = LOADER_AW,
  parameter int CW = LOADER_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_data,
  input  logic          in_last,
  output logic          im_we,
  output logic [AW-1:0] im_waddr,
  output logic [IW-1:0] im_wdata,
  output logic          cpu_reset,
  output logic          cpu_start,
  input  logic          cpu_done,
  output logic          busy,
  output logic          run_done,
  input  logic          ack,
  output logic [AW:0]   word_count,
  output logic [CW-1:0] cycle_count,
  output logic          err_overflow,
  output logic          err_timeout
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  loader_state_t state;
  loader_state_t next_state;
  logic          beat;
  logic          first_beat;
  logic          load_beat;
  logic          mem_full;
  logic          ovf_now;
  logic [1:0]    boot_cnt;
  logic          boot_last;
  logic          timeout_hit;

  assign in_ready   = reset && ((state == ST_IDLE) || (state == ST_LOAD));
  assign beat       = in_valid && in_ready;
  assign first_beat = beat && (state == ST_IDLE);
  assign load_beat  = beat && (state == ST_LOAD);
  assign mem_full   = (word_count == DEPTH);
  // Overflow including a beat being dropped right now, so an overflowing
  // in_last beat already skips the run.
  assign ovf_now    = err_overflow || (load_beat && mem_full);
  assign boot_last  = (boot_cnt == 2'(LOADER_BOOT_CYCLES - 1));

  // Counts BOOT cycles; held at zero in every other state.
  pebble_sat_ctr #(.W(2)) u_boot_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (state != ST_BOOT),
    .en    (state == ST_BOOT),
    .count (boot_cnt)
  );

  // Run-length counter: zeroed on the start pulse and on a new program.
  pebble_sat_ctr #(.W(CW)) u_cycle_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (first_beat || (state == ST_START)),
    .en    (state == ST_RUN),
    .count (cycle_count)
  );

`ifdef PEBBLE_LOADER_TIMEOUT_EN
  // The count reaches LOADER_TIMEOUT on the edge that ends this RUN cycle.
  assign timeout_hit = (cycle_count == (CW'(LOADER_TIMEOUT) - CW'(1)));

  // Watchdog flag; a simultaneous cpu_done takes precedence.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_timeout <= 1'b0;
    end else if (first_beat) begin
      err_timeout <= 1'b0;
    end else if ((state == ST_RUN) && !cpu_done && timeout_hit) begin
      err_timeout <= 1'b1;
    end else begin
      err_timeout <= err_timeout;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (first_beat) next_state = in_last ? ST_BOOT : ST_LOAD;
        else            next_state = ST_IDLE;
      end
      ST_LOAD: begin
        if (load_beat && in_last) next_state = ovf_now ? ST_DONE : ST_BOOT;
        else                      next_state = ST_LOAD;
      end
      ST_BOOT: begin
        if (boot_last) next_state = ST_START;
        else           next_state = ST_BOOT;
      end
      ST_START: next_state = ST_RUN;
      ST_RUN: begin
        if (cpu_done)         next_state = ST_DONE;
        else if (timeout_hit) next_state = ST_DONE;
        else                  next_state = ST_RUN;
      end
      ST_DONE: begin
        if (ack) next_state = ST_IDLE;
        else     next_state = ST_DONE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Registered outputs: memory write port, counters, flags and core controls
  // decoded from the state being entered so they line up with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      im_we        <= 1'b0;
      im_waddr     <= '0;
      im_wdata     <= '0;
      word_count   <= '0;
      err_overflow <= 1'b0;
      cpu_reset    <= 1'b1;
      cpu_start    <= 1'b0;
      busy         <= 1'b0;
      run_done     <= 1'b0;
    end else begin
      im_we <= 1'b0;
      if (first_beat) begin
        im_we        <= 1'b1;
        im_waddr     <= '0;
        im_wdata     <= in_data;
        word_count   <= (AW+1)'(1);
        err_overflow <= 1'b0;
      end else if (load_beat) begin
        if (mem_full) begin
          err_overflow <= 1'b1;
        end else begin
          im_we      <= 1'b1;
          im_waddr   <= word_count[AW-1:0];
          im_wdata   <= in_data;
          word_count <= word_count + (AW+1)'(1);
        end
      end else begin
        word_count <= word_count;
      end
      cpu_reset <= (next_state == ST_IDLE) || (next_state == ST_LOAD) ||
                   (next_state == ST_BOOT) || (next_state == ST_DONE);
      cpu_start <= (next_state == ST_START);
      busy      <= (next_state != ST_IDLE);
      run_done  <= (next_state == ST_DONE);
    end
  end

endmodule

// File: tb/tb_pebble_loader.sv
// Directed testbench for pebble_loader (default parameters).
module tb_pebble_loader;
  import pebble_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  in_data = 9'd0;
  logic        in_last = 1'b0;
  logic        im_we;
  logic [9:0]  im_waddr;
  logic [8:0]  im_wdata;
  logic        cpu_reset;
  logic        cpu_start;
  logic        cpu_done = 1'b0;
  logic        busy;
  logic        run_done;
  logic        ack = 1'b0;
  logic [10:0] word_count;
  logic [15:0] cycle_count;
  logic        err_overflow;
  logic        err_timeout;

  int n_total = 0;
  int n_pass  = 0;
  int writes  = 0;
  int starts  = 0;
  int base_w;
  int base_s;
  logic [8:0] wmem [0:1023];

  pebble_loader dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .im_we(im_we), .im_waddr(im_waddr),
    .im_wdata(im_wdata), .cpu_reset(cpu_reset), .cpu_start(cpu_start),
    .cpu_done(cpu_done), .busy(busy), .run_done(run_done), .ack(ack),
    .word_count(word_count), .cycle_count(cycle_count),
    .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Memory-write and start-pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (im_we) begin
      wmem[im_waddr] = im_wdata;
      writes = writes + 1;
    end
    if (cpu_start) starts = starts + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [8:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    step();
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_im_we", 32'(im_we), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_cycle_count", 32'(cycle_count), 32'd0);
    check("rst_flags", {30'd0, err_overflow, err_timeout}, 32'd0);
    reset = 1'b1;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Three-word program, start pulse timing, done on first RUN cycle
    base_w = writes;
    base_s = starts;
    send(9'h1A5, 1'b0);
    send(9'h0F0, 1'b0);
    send(9'h1FF, 1'b1);
    check("t1_writes", 32'(writes - base_w), 32'd3);
    check("t1_mem0", 32'(wmem[0]), 32'h1A5);
    check("t1_mem1", 32'(wmem[1]), 32'h0F0);
    check("t1_mem2", 32'(wmem[2]), 32'h1FF);
    check("t1_word_count", 32'(word_count), 32'd3);
    check("t1_boot1", {29'd0, cpu_reset, cpu_start, in_ready}, 32'b100);
    step();
    check("t1_boot2", {29'd0, cpu_reset, cpu_start, busy}, 32'b101);
    step();
    check("t1_start", {30'd0, cpu_reset, cpu_start}, 32'b01);
    step();
    check("t1_run1_nostart", 32'(cpu_start), 32'd0);
    check("t1_starts", 32'(starts - base_s), 32'd1);
    cpu_done = 1'b1;
    step();
    cpu_done = 1'b0;
    check("t1_run_done", 32'(run_done), 32'd1);
    check("t1_cycle_count", 32'(cycle_count), 32'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("t1_busy_after_ack", 32'(busy), 32'd0);

    // One-word program, cpu_done on the 5th RUN cycle
    send(9'h0C3, 1'b1);
    check("t2_waddr", 32'(im_waddr), 32'd0);
    check("t2_wdata", 32'(im_wdata), 32'h0C3);
    repeat (7) step();
    cpu_done = 1'b1;
    step();
    cpu_done = 1'b0;
    check("t2_run_done", 32'(run_done), 32'd1);
    check("t2_cycle_count", 32'(cycle_count), 32'd5);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_run_done_clr", 32'(run_done), 32'd0);
    check("t2_keep_wc", 32'(word_count), 32'd1);
    check("t2_keep_cc", 32'(cycle_count), 32'd5);

    // Gaps in LOAD; in_valid, cpu_done and ack driven where they must be ignored
    base_w = writes;
    send(9'h055, 1'b0);
    step();
    check("t3_gap_ready", 32'(in_ready), 32'd1);
    step();
    send(9'h123, 1'b1);
    in_valid = 1'b1;
    cpu_done = 1'b1;
    ack      = 1'b1;
    check("t3_boot_ready", 32'(in_ready), 32'd0);
    repeat (3) step();
    cpu_done = 1'b0;
    ack      = 1'b0;
    check("t3_early_done_ignored", 32'(run_done), 32'd0);
    check("t3_run_ready", 32'(in_ready), 32'd0);
    repeat (2) step();
    cpu_done = 1'b1;
    step();
    cpu_done = 1'b0;
    check("t3_cycle_count", 32'(cycle_count), 32'd3);
    repeat (2) step();
    check("t3_done_ready", 32'(in_ready), 32'd0);
    check("t3_done_hold", 32'(run_done), 32'd1);
    check("t3_writes", 32'(writes - base_w), 32'd2);
    check("t3_mem1", 32'(wmem[1]), 32'h123);
    check("t3_word_count", 32'(word_count), 32'd2);
    in_valid = 1'b0;
    ack = 1'b1;
    step();
    ack = 1'b0;

    // 1025-word program overflows a 1024-word memory
    base_w = writes;
    base_s = starts;
    for (int i = 0; i < 1025; i++) begin
      send(9'(i), (i == 1024));
    end
    check("t4_writes", 32'(writes - base_w), 32'd1024);
    check("t4_word_count", 32'(word_count), 32'd1024);
    check("t4_overflow", 32'(err_overflow), 32'd1);
    check("t4_run_done", 32'(run_done), 32'd1);
    check("t4_mem1000", 32'(wmem[1000]), 32'h1E8);
    check("t4_mem1023", 32'(wmem[1023]), 32'h1FF);
    repeat (5) step();
    check("t4_no_start", 32'(starts - base_s), 32'd0);
    check("t4_cpu_reset", 32'(cpu_reset), 32'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("t4_keep_ovf", 32'(err_overflow), 32'd1);

    // Reset in the middle of LOAD, then reload from address 0
    send(9'h101, 1'b0);
    send(9'h102, 1'b0);
    send(9'h103, 1'b0);
    send(9'h104, 1'b0);
    check("t5_wc_before", 32'(word_count), 32'd4);
    reset = 1'b0;
    step();
    check("t5_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t5_word_count", 32'(word_count), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_ready_in_reset", 32'(in_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("t5_ready_after", 32'(in_ready), 32'd1);
    base_w = writes;
    send(9'h0AA, 1'b1);
    check("t5_reload", {20'd0, im_we, im_waddr, 1'b0}, {20'd0, 1'b1, 10'd0, 1'b0});
    check("t5_reload_data", 32'(im_wdata), 32'h0AA);
    check("t5_reload_wc", 32'(word_count), 32'd1);
    repeat (3) step();

`ifdef PEBBLE_LOADER_TIMEOUT_EN
    // Watchdog ends a run that never signals done
    for (int k = 0; k < int'(LOADER_TIMEOUT) + 20; k++) begin
      if (run_done) break;
      step();
    end
    check("t6_run_done", 32'(run_done), 32'd1);
    check("t6_err_timeout", 32'(err_timeout), 32'd1);
    check("t6_cycle_count", 32'(cycle_count), 32'(LOADER_TIMEOUT));
`else
    // Without the watchdog the run waits for cpu_done
    repeat (30) step();
    check("t6_still_running", {30'd0, run_done, busy}, 32'b01);
    check("t6_err_timeout", 32'(err_timeout), 32'd0);
    cpu_done = 1'b1;
    step();
    cpu_done = 1'b0;
    check("t6_run_done", 32'(run_done), 32'd1);
    check("t6_cycle_count", 32'(cycle_count), 32'd31);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
